// File: rtl/bear_pkg.sv
// ---------------------------------------------------------------------------
// bear_pkg
// Shared definitions for the BEAR ADC readout controller:
//   - bear_state_e : readout FSM states
//   - BEAR_DATA_W  : default bits per ADC word
//   - BEAR_NUM_CH  : default channels read per frame
//   - BEAR_CH_W    : width of the channel index
// ---------------------------------------------------------------------------
package bear_pkg;

  localparam int BEAR_DATA_W = 10;
  localparam int BEAR_NUM_CH = 3;
  localparam int BEAR_CH_W   = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_RDY = 3'd2,
    SHIFT    = 3'd3,
    HOLD     = 3'd4
  } bear_state_e;

endpackage

// File: rtl/bear_readout_ctrl_if.sv
// ---------------------------------------------------------------------------
// bear_readout_ctrl_if
// Bundles the chip-side and consumer-side signals of the BEAR readout block.
//   Requester : frame_req
//   Chip      : ready, serout (to controller); start, bear_clk (to chip)
//   Consumer  : word_data, word_valid, ch_idx (to consumer); word_ack
//   Status    : busy, overrun, timeout
// Modports:
//   master : the readout controller
//   slave  : the environment (sequencer, chip, UART path)
// ---------------------------------------------------------------------------
interface bear_readout_ctrl_if
  import bear_pkg::*;
#(
  parameter int DATA_W = BEAR_DATA_W
);

  logic                 frame_req;
  logic                 ready;
  logic                 serout;
  logic                 start;
  logic                 bear_clk;
  logic [DATA_W-1:0]    word_data;
  logic                 word_valid;
  logic                 word_ack;
  logic [BEAR_CH_W-1:0] ch_idx;
  logic                 busy;
  logic                 overrun;
  logic                 timeout;

  modport master (
    input  frame_req, ready, serout, word_ack,
    output start, bear_clk, word_data, word_valid, ch_idx, busy, overrun, timeout
  );

  modport slave (
    output frame_req, ready, serout, word_ack,
    input  start, bear_clk, word_data, word_valid, ch_idx, busy, overrun, timeout
  );

endinterface

// File: rtl/bear_clk_gen.sv
// ---------------------------------------------------------------------------
// bear_clk_gen
// Half-period divider producing the BEAR shift clock.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   i_en         : run the divider; when low the clock is held low and the
//                  divider restarts from the beginning of a low phase
//   o_bear_clk   : registered shift clock (CLK_DIV cycles low, CLK_DIV high)
//   o_rise       : one-cycle strobe in the cycle whose closing edge drives
//                  o_bear_clk 0->1
//   o_fall_done  : one-cycle strobe in the last cycle of a high phase
// ---------------------------------------------------------------------------
module bear_clk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_bear_clk,
  output logic o_rise,
  output logic o_fall_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_div;
  logic             r_phase;
  logic             w_half_done;

  assign w_half_done = i_en && (r_div == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (w_half_done) begin
      r_div   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_div   <= r_div + 1'b1;
    end
  end

  assign o_bear_clk  = r_phase;
  assign o_rise      = w_half_done & ~r_phase;
  assign o_fall_done = w_half_done &  r_phase;

endmodule

// File: rtl/bear_readout_ctrl.sv
// ---------------------------------------------------------------------------
// bear_readout_ctrl
// Sequences one BEAR ADC frame: for each channel pulse start, wait for the
// chip's ready edge, clock DATA_W bits out of serout MSB-first and present
// the word to the UART/display path through a valid/ack handshake.
// Ports:
//   sys_clk : system clock, all logic on rising edge
//   reset   : synchronous active-high reset, returns the block to IDLE
//   bus     : bear_readout_ctrl_if.master
//             frame_req/ready/serout/word_ack in;
//             start/bear_clk/word_data/word_valid/ch_idx/busy/overrun/timeout out
// Build option:
//   BEAR_RDY_TIMEOUT_EN : when defined, a ready wait longer than TIMEOUT
//                         cycles (counted from the start pulse) sets the
//                         sticky timeout flag and abandons the frame; when
//                         undefined the ready wait is unbounded and timeout
//                         is tied low.
// ---------------------------------------------------------------------------
module bear_readout_ctrl
  import bear_pkg::*;
#(
  parameter int DATA_W  = BEAR_DATA_W,
  parameter int NUM_CH  = BEAR_NUM_CH,
  parameter int CLK_DIV = 50,
  parameter int TIMEOUT = 100000
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  bear_readout_ctrl_if.master   bus
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  if (CLK_DIV < 1 || TIMEOUT < 1 || DATA_W < 2 || NUM_CH < 1 || NUM_CH > (1 << BEAR_CH_W))
  begin : g_param_check
    $error("bear_readout_ctrl: unsupported parameter set");
  end

  bear_state_e              r_state;
  bear_state_e              w_next_state;

  logic                     r_rdy_s1;
  logic                     r_rdy_s2;
  logic                     r_rdy_s3;
  logic [DATA_W-1:0]        r_shift;
  logic [DATA_W-1:0]        r_word;
  logic [BIT_W-1:0]         r_bit_cnt;
  logic [BEAR_CH_W-1:0]     r_ch_idx;
  logic                     r_overrun;

  logic                     w_rdy_rise;
  logic                     w_accept;
  logic                     w_last_pulse;
  logic                     w_last_ch;
  logic                     w_to_expire;
  logic                     w_clk_en;
  logic                     w_bear_clk;
  logic                     w_rise;
  logic                     w_fall_done;

  // s1/s2 form the synchroniser; s3 only remembers the previous synchronised
  // level, so a ready already high on entry to WAIT_RDY is not an edge.
  assign w_rdy_rise   = r_rdy_s2 & ~r_rdy_s3;
  assign w_accept     = (r_state == IDLE) && bus.frame_req;
  assign w_last_pulse = (r_bit_cnt == BIT_W'(DATA_W - 1));
  assign w_last_ch    = (r_ch_idx == BEAR_CH_W'(NUM_CH - 1));

  bear_clk_gen #(
    .CLK_DIV     (CLK_DIV)
  ) u_clk_gen (
    .clk         (sys_clk),
    .rst         (reset),
    .i_en        (w_clk_en),
    .o_bear_clk  (w_bear_clk),
    .o_rise      (w_rise),
    .o_fall_done (w_fall_done)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.frame_req) begin
          w_next_state = START;
        end
      end
      START: begin
        w_next_state = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (w_rdy_rise) begin
          w_next_state = SHIFT;
        end else if (w_to_expire) begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (w_fall_done && w_last_pulse) begin
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.word_ack) begin
          w_next_state = w_last_ch ? IDLE : START;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    bus.start      = 1'b0;
    bus.busy       = 1'b1;
    bus.word_valid = 1'b0;
    w_clk_en       = 1'b0;
    case (r_state)
      IDLE:     bus.busy       = 1'b0;
      START:    bus.start      = 1'b1;
      SHIFT:    w_clk_en       = 1'b1;
      HOLD:     bus.word_valid = 1'b1;
      default:  ;
    endcase
  end

  // Synchroniser, shift register, word latch, counters, overrun flag
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_rdy_s1  <= 1'b0;
      r_rdy_s2  <= 1'b0;
      r_rdy_s3  <= 1'b0;
      r_shift   <= '0;
      r_word    <= '0;
      r_bit_cnt <= '0;
      r_ch_idx  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_rdy_s1 <= bus.ready;
      r_rdy_s2 <= r_rdy_s1;
      r_rdy_s3 <= r_rdy_s2;

      if (w_accept) begin
        r_ch_idx <= '0;
      end else if ((r_state == HOLD) && bus.word_ack && !w_last_ch) begin
        r_ch_idx <= r_ch_idx + 1'b1;
      end

      // A ready edge while shifting or holding is only flagged; the FSM
      // never sees it because WAIT_RDY is the only state that consumes it.
      if (w_accept) begin
        r_overrun <= 1'b0;
      end else if (w_rdy_rise && ((r_state == SHIFT) || (r_state == HOLD))) begin
        r_overrun <= 1'b1;
      end

      if (r_state != SHIFT) begin
        r_bit_cnt <= '0;
      end else if (w_fall_done) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      // The shift happens on the same edge that drives bear_clk high.
      if (w_rise) begin
        r_shift <= {r_shift[DATA_W-2:0], bus.serout};
      end

      if (w_fall_done && w_last_pulse) begin
        r_word <= r_shift;
      end
    end
  end

`ifdef BEAR_RDY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 2);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  // The count is preloaded in START so the budget is measured from the
  // start pulse itself: with TIMEOUT=N the abort is visible N cycles later.
  assign w_to_expire = (r_state == WAIT_RDY) && !w_rdy_rise &&
                       (r_to_cnt >= TO_W'(TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == START) begin
        r_to_cnt <= TO_W'(1);
      end else if (r_state == WAIT_RDY) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end

      if (w_accept) begin
        r_timeout <= 1'b0;
      end else if (w_to_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_to_expire = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.bear_clk  = w_bear_clk;
  assign bus.word_data = r_word;
  assign bus.ch_idx    = r_ch_idx;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_bear_readout_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bear_readout_ctrl
// Drives bear_readout_ctrl with a behavioural BEAR chip model (start ->
// delayed ready pulse -> serout MSB-first on bear_clk) and a consumer with a
// programmable ack delay. Expected words are queued when a frame is
// requested and compared when the consumer accepts them.
// ---------------------------------------------------------------------------
module tb_bear_readout_ctrl;
  import bear_pkg::*;

  localparam int DATA_W  = 10;
  localparam int NUM_CH  = 3;
  localparam int CLK_DIV = 2;
  localparam int TIMEOUT = 50;
  localparam int RDY_DLY = 3;

  typedef struct {
    logic [DATA_W-1:0]    data;
    logic [BEAR_CH_W-1:0] ch;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bear_readout_ctrl_if #(.DATA_W(DATA_W)) bus ();

  bear_readout_ctrl #(
    .DATA_W  (DATA_W),
    .NUM_CH  (NUM_CH),
    .CLK_DIV (CLK_DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [DATA_W-1:0] chip_q[$];
  exp_t              exp_q[$];

  logic rdy_auto   = 1'b0;
  logic rdy_manual = 1'b0;
  assign bus.ready = rdy_auto | rdy_manual;

  bit   auto_en       = 1'b1;
  int   ack_wait      = 0;
  int   cyc           = 0;
  int   idx           = 0;
  int   rdy_cnt       = -1;
  int   rdy_hi        = 0;
  int   wait_cnt      = 0;
  int   rise_cnt      = 0;
  int   first_rise    = 0;
  int   words_rx      = 0;
  int   start_cnt     = 0;
  int   valid_seen    = 0;
  int   bp_bad        = 0;
  int   last_ack_cyc  = 0;
  int   last_start_cyc = 0;
  logic prev_bclk     = 1'b0;
  logic [DATA_W-1:0] cur_word = '0;
  logic [DATA_W-1:0] bp_ref   = '0;

  // Chip model and consumer, evaluated mid-cycle
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      rdy_auto     = 1'b0;
      bus.word_ack = 1'b0;
      bus.serout   = 1'b0;
      idx          = 0;
      rdy_cnt      = -1;
      rdy_hi       = 0;
      wait_cnt     = 0;
      rise_cnt     = 0;
      prev_bclk    = 1'b0;
    end else begin
      if (bus.word_valid) valid_seen++;

      if (bus.start) begin
        start_cnt++;
        last_start_cyc = cyc;
        idx      = 0;
        rise_cnt = 0;
        cur_word = (chip_q.size() > 0) ? chip_q.pop_front() : '0;
        rdy_cnt  = RDY_DLY;
      end else if (bus.bear_clk && !prev_bclk) begin
        idx++;
        rise_cnt++;
        if (rise_cnt == 1) first_rise = cyc;
      end
      prev_bclk  = bus.bear_clk;
      bus.serout = (idx < DATA_W) ? cur_word[DATA_W-1-idx] : 1'b0;

      if (rdy_cnt > 0) begin
        rdy_cnt--;
      end else if (rdy_cnt == 0) begin
        rdy_cnt = -1;
        if (auto_en) begin
          rdy_auto = 1'b1;
          rdy_hi   = 4;
        end
      end else if (rdy_hi > 0) begin
        rdy_hi--;
        if (rdy_hi == 0) rdy_auto = 1'b0;
      end

      if (bus.word_valid && !bus.word_ack) begin
        if (wait_cnt == 0) begin
          bp_ref = bus.word_data;
          chk("pulses", rise_cnt, DATA_W);
          chk("shift_span", cyc - first_rise, 2 * CLK_DIV * DATA_W - CLK_DIV);
        end else if (bus.word_data !== bp_ref || bus.bear_clk !== 1'b0) begin
          bp_bad++;
        end
        if (wait_cnt >= ack_wait) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", bus.word_data, e.data);
            chk("ch_idx", bus.ch_idx, e.ch);
          end
          bus.word_ack = 1'b1;
          last_ack_cyc = cyc;
          wait_cnt     = 0;
          words_rx++;
        end else begin
          wait_cnt++;
        end
      end else begin
        bus.word_ack = 1'b0;
      end
    end
  end

  task automatic req_frame(input logic [DATA_W-1:0] w0, w1, w2);
    logic [DATA_W-1:0] w[3];
    exp_t e;
    w = '{w0, w1, w2};
    for (int i = 0; i < NUM_CH; i++) begin
      chip_q.push_back(w[i]);
      e.data = w[i];
      e.ch   = BEAR_CH_W'(i);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.frame_req = 1'b1;
    @(negedge clk);
    bus.frame_req = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("accept_start", bus.start, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("wait_idle", bus.busy, 0);
  endtask

  task automatic wait_rises(input int n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rise_cnt >= n) break;
    end
    chk("wait_rises", (rise_cnt >= n), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"},      bus.start, 0);
    chk({tag, "_bear_clk"},   bus.bear_clk, 0);
    chk({tag, "_word_data"},  bus.word_data, 0);
    chk({tag, "_word_valid"}, bus.word_valid, 0);
    chk({tag, "_ch_idx"},     bus.ch_idx, 0);
    chk({tag, "_busy"},       bus.busy, 0);
    chk({tag, "_overrun"},    bus.overrun, 0);
    chk({tag, "_timeout"},    bus.timeout, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int s0;
    bus.frame_req = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain frame: three channels, immediate ack
    w0 = words_rx;
    req_frame(10'h2AD, 10'h155, 10'h0F0);
    wait_idle(2000);
    chk("t1_words", words_rx - w0, 3);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_overrun", bus.overrun, 0);

    // Back-pressure: hold each word for 500 extra cycles
    ack_wait = 500;
    bp_bad   = 0;
    w0 = words_rx;
    req_frame(10'h3A5, 10'h001, 10'h200);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (words_rx > w0) break;
    end
    repeat (3) @(negedge clk);
    chk("t2_start_after_ack", last_start_cyc - last_ack_cyc, 1);
    wait_idle(5000);
    chk("t2_bp_stable", bp_bad, 0);
    chk("t2_words", words_rx - w0, 3);
    ack_wait = 0;

    // Overrun: extra ready pulse during ch0 shift
    w0 = words_rx;
    req_frame(10'h123, 10'h2DB, 10'h3FE);
    wait_rises(3);
    rdy_manual = 1'b1;
    repeat (4) @(negedge clk);
    rdy_manual = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_overrun_set", bus.overrun, 1);
    wait_idle(2000);
    chk("t3_overrun_sticky", bus.overrun, 1);
    chk("t3_words", words_rx - w0, 3);

    // Reset mid-shift, then a clean frame of all-ones
    req_frame(10'h0AA, 10'h0BB, 10'h0CC);
    chk("t4_overrun_cleared", bus.overrun, 0);
    wait_rises(5);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("t4_rst");
    @(negedge clk);
    reset = 1'b0;
    chip_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    w0 = words_rx;
    req_frame(10'h3FF, 10'h3FF, 10'h3FF);
    wait_idle(2000);
    chk("t4_words", words_rx - w0, 3);

    // Second request while the first frame waits for ready
    w0 = words_rx;
    s0 = start_cnt;
    req_frame(10'h111, 10'h222, 10'h333);
    @(negedge clk);
    bus.frame_req = 1'b1;
    @(negedge clk);
    bus.frame_req = 1'b0;
    wait_idle(2000);
    repeat (100) @(negedge clk);
    chk("t5_words", words_rx - w0, 3);
    chk("t5_starts", start_cnt - s0, 3);
    chk("t5_busy", bus.busy, 0);
    chk("t5_queue_empty", exp_q.size(), 0);

`ifdef BEAR_RDY_TIMEOUT_EN
    // Ready never arrives
    auto_en = 1'b0;
    s0 = valid_seen;
    @(negedge clk);
    bus.frame_req = 1'b1;
    @(negedge clk);
    bus.frame_req = 1'b0;
    chk("t6_start", bus.start, 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("t6_busy_before", bus.busy, 1);
    chk("t6_timeout_before", bus.timeout, 0);
    @(negedge clk);
    chk("t6_timeout", bus.timeout, 1);
    chk("t6_busy_after", bus.busy, 0);
    repeat (100) @(negedge clk);
    chk("t6_no_valid", valid_seen - s0, 0);
    chk("t6_timeout_sticky", bus.timeout, 1);
    auto_en = 1'b1;
`else
    chk("timeout_tied_low", bus.timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
